// File: rtl/multi_pulse_detector.sv
// multi_pulse_detector: per-channel high-run length classifier with a saturating count of in-window pulses
module multi_pulse_detector #(
    parameter int N_CH = 4,
    parameter int MAX_LEN = 15,
    parameter int TOT_W = 16,
    localparam int CNT_W = $clog2(MAX_LEN + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  a,
    input  logic [N_CH-1:0]  en,
    input  logic [CNT_W-1:0] len_min,
    input  logic [CNT_W-1:0] len_max,
    output logic [N_CH-1:0]  rise,
    output logic [N_CH-1:0]  fall,
    output logic [N_CH-1:0]  pulse_ok,
    output logic [N_CH-1:0]  pulse_bad,
    output logic [TOT_W-1:0] pulse_total
);
    typedef enum logic [1:0] {ARM, LOW, HIGH} state_t;
    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_LEN + 1);
    localparam int PW = $clog2(N_CH + 1);
    localparam int SW = TOT_W + PW + 1;
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};
    state_t state [N_CH];
    state_t state_nx [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] cnt_nx [N_CH];
    logic [CNT_W-1:0] lo;
    logic [PW-1:0] pc;
    logic [SW-1:0] sum;
    assign lo = len_min == '0 ? CNT_W'(1) : len_min;
    // a saturated cnt is MAX_LEN+1, so it always lands above any len_max <= MAX_LEN
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign rise[g] = ~rst & en[g] & a[g] & (state[g] == LOW);
        assign fall[g] = ~rst & en[g] & ~a[g] & (state[g] == HIGH);
        assign pulse_ok[g] = fall[g] & (cnt[g] >= lo) & (cnt[g] <= len_max);
        assign pulse_bad[g] = fall[g] & ~pulse_ok[g];
    end
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i] = cnt[i];
            if (!en[i]) begin
                state_nx[i] = ARM;
                cnt_nx[i] = '0;
            end else begin
                case (state[i])
                    ARM: state_nx[i] = a[i] ? ARM : LOW;
                    LOW: begin
                        state_nx[i] = a[i] ? HIGH : LOW;
                        cnt_nx[i] = a[i] ? CNT_W'(1) : '0;
                    end
                    HIGH: begin
                        state_nx[i] = a[i] ? HIGH : LOW;
                        cnt_nx[i] = !a[i] ? '0 : (cnt[i] == SAT ? SAT : cnt[i] + CNT_W'(1));
                    end
                    default: begin
                        state_nx[i] = ARM;
                        cnt_nx[i] = '0;
                    end
                endcase
            end
        end
    end
    always_comb begin
        pc = '0;
        for (int i = 0; i < N_CH; i++) pc = pc + PW'(pulse_ok[i]);
        sum = SW'(pulse_total) + SW'(pc);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= ARM;
                cnt[i] <= '0;
            end
            pulse_total <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nx[i];
                cnt[i] <= cnt_nx[i];
            end
            pulse_total <= sum > SW'(TOT_MAX) ? TOT_MAX : sum[TOT_W-1:0];
        end
    end
endmodule

// File: doc/multi_pulse_detector.md
MULTI_PULSE_DETECTOR -- requirements
Module: multi_pulse_detector

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter MAX_LEN, default 15: largest pulse length, in cycles, that is measured exactly; CNT_W = $clog2(MAX_LEN+2).
REQ-003 Parameter TOT_W, default 16: width of the global valid-pulse counter.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port a  input  N_CH: sampled channel inputs, bit i is channel i.
REQ-007 Port en  input  N_CH: per-channel enable.
REQ-008 Port len_min  input  CNT_W: shortest accepted high-run length; a value of 0 is treated as 1.
REQ-009 Port len_max  input  CNT_W: longest accepted high-run length.
REQ-010 Port rise  output  N_CH: per-channel rising-edge strobe.
REQ-011 Port fall  output  N_CH: per-channel falling-edge strobe.
REQ-012 Port pulse_ok  output  N_CH: high run ended with length L, where len_min <= L <= len_max.
REQ-013 Port pulse_bad  output  N_CH: high run ended with L outside the window.
REQ-014 Port pulse_total  output  TOT_W: saturating count of all pulse_ok strobes.

Function
REQ-015 Each channel SHALL hold a state in {ARM, LOW, HIGH} and a run counter cnt[CNT_W-1:0].
REQ-016 Channel transitions:
- ARM -> LOW when en=1 and a=0.
- LOW -> HIGH when en=1 and a=1, loading cnt=1.
- HIGH with a=1: cnt = min(cnt+1, MAX_LEN+1).
- HIGH with a=0: go to LOW and clear cnt to 0.
REQ-017 When en=0, a channel SHALL go to ARM with cnt=0 on the next edge, and all of its outputs SHALL be 0 in that cycle.
REQ-018 A run SHALL count only after a low was observed; a=1 held through reset or through enable does not count as a rise.
REQ-019 rise[i] SHALL be combinational: state LOW & en & a. It is asserted in the first high cycle.
REQ-020 fall[i] SHALL be combinational: state HIGH & en & ~a. It is asserted in the first low cycle after the run.
REQ-021 pulse_ok[i] and pulse_bad[i] SHALL be asserted only with fall[i]; exactly one of them is set, based on cnt compared with the len_min/len_max values present in that same cycle.
REQ-022 A saturated cnt (MAX_LEN+1) SHALL compare as greater than any len_max <= MAX_LEN.
REQ-023 When len_min > len_max, every completed run SHALL give pulse_bad.
REQ-024 Changing len_min or len_max mid-run SHALL NOT reset cnt; only the values present at the fall are used.
REQ-025 Latency: a 0-1-0 sequence on a (L=1) SHALL assert rise in the '1' cycle and fall with pulse_ok or pulse_bad in the following '0' cycle.
REQ-026 pulse_total SHALL add popcount(pulse_ok) on each edge and saturate at 2^TOT_W-1; it never wraps.
REQ-027 Back-to-back pulses (1-0-1) SHALL assert fall and rise in consecutive cycles; no cycle is lost.
REQ-028 Channels SHALL be fully independent, and simultaneous events on all channels SHALL be counted correctly.

Reset
REQ-029 While rst=1, on each edge: all channels go to ARM, cnt=0, and pulse_total=0.
REQ-030 While rst=1, rise, fall, pulse_ok and pulse_bad SHALL be forced to 0 combinationally.
REQ-031 A reset asserted mid-run SHALL discard the run; the first fall after reset is not reported unless a low is seen first.

Verification
REQ-032 N_CH=4, en=F, len_min=len_max=1, ch0 a=0,1,0 -> rise[0] in cycle 2, fall[0] and pulse_ok[0] in cycle 3, pulse_total=1 after that edge.
REQ-033 ch1 high for 3 cycles, window [1,2] -> pulse_bad[1] at the fall, pulse_ok=0, pulse_total unchanged.
REQ-034 MAX_LEN=15, ch2 high for 40 cycles, len_max=15 -> cnt saturates at 16; pulse_bad at the fall, with no wrap to a short length.
REQ-035 a=F held across rst deassertion, then a=0 -> no rise and no fall; a later 0-1-0 is detected normally.
REQ-036 All 4 channels pulse with L=2, window [2,2], simultaneously -> pulse_ok=F, pulse_total +4; with pulse_total preset near max by a long run, it stops at 2^TOT_W-1.
REQ-037 rst or en=0 asserted during a high run -> no fall or pulse strobe for that run; len_min > len_max case -> pulse_bad only.
